// File: rtl/pipe_pkg.sv
// Shared definitions for every pipeline-stage buffer instance: the stage
// occupancy encoding and the per-boundary control-bundle widths.
package pipe_pkg;

  // Occupancy of a stage buffer. The encoding equals the number of entries
  // held, so the state register doubles as the count output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int COUNT_W = 2;

  // Control-bundle widths for each pipeline boundary.
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_CTRL_W  = 10;
  localparam int EXMEM_CTRL_W = 6;
  localparam int MEMWB_CTRL_W = 3;

  localparam int DEFAULT_DATA_W = 64;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register: a valid bit, a control bundle and a data bundle.
// A clear of the control bundle wins over a load, so a slot that is being
// emptied or flushed never carries live control bits.
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr_valid,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next-entry selection: hold, load, then apply clears on top.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      ctrl_d  = d_ctrl;
      data_d  = d_data;
    end
    if (clr_valid) valid_d = 1'b0;
    if (clr_ctrl)  ctrl_d  = '0;
  end

  // Entry registers with synchronous reset to an all-zero bubble.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake between two stages.
// SKID=1: main slot plus skid slot, in_ready comes from a flop, so a stall
// costs one extra entry of storage but breaks the ready timing path.
// SKID=0: single slot, in_ready is combinational from out_ready.
// flush kills everything held and any same-cycle input, leaving a bubble
// with zeroed control bits.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  stage_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              accept;
  logic              emit;
  logic              main_load;
  logic              main_clr;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clr;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;

  assign in_ready = SKID ? in_ready_q : (~main_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign emit     = main_valid & out_ready;

  // Occupancy transitions and slot load/clear controls. In single-slot mode
  // ST_FULL is unreachable: in ST_ONE an accept always implies an emit.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !emit) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (accept && emit) begin
            main_load = 1'b1;
          end else if (emit) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // The skid entry is always older than the input, so it refills main first.
  always_comb begin
    main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    main_ld_data = main_from_skid ? skid_data : in_data;
  end

  // Occupancy state and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clr_valid (main_clr),
    .clr_ctrl  (main_clr),
    .d_ctrl    (main_ld_ctrl),
    .d_data    (main_ld_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clr_valid (skid_clr),
        .clr_ctrl  (skid_clr),
        .d_ctrl    (in_ctrl),
        .d_data    (in_data),
        .valid     (skid_valid),
        .ctrl      (skid_ctrl),
        .data      (skid_data)
      );
    end else begin : g_no_skid
      logic unused_skid_ctl;
      assign skid_valid      = 1'b0;
      assign skid_ctrl       = '0;
      assign skid_data       = '0;
      assign unused_skid_ctl = skid_load | skid_clr;
    end
  endgenerate

  // Skid occupancy is already encoded in state_q; the slot's own valid bit
  // is kept for debug visibility only.
  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: one instance with the skid slot and
// one single-slot instance, each driven through a linear sequence of steps.
module tb_pipe_stage_buffer;

  localparam int DW = 64;
  localparam int CW = 10;

  logic          clk;
  int            checks;
  int            failures;

  // Skid-mode instance signals
  logic          rst1, flush1, iv1, ir1, ov1, or1;
  logic [CW-1:0] ic1, oc1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    cnt1;

  // Single-slot instance signals
  logic          rst0, flush0, iv0, ir0, ov0, or0;
  logic [CW-1:0] ic0, oc0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    cnt0;

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .flush     (flush1),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .in_ctrl   (ic1),
    .in_data   (id1),
    .out_valid (ov1),
    .out_ready (or1),
    .out_ctrl  (oc1),
    .out_data  (od1),
    .count     (cnt1)
  );

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) u_dut0 (
    .clk       (clk),
    .rst       (rst0),
    .flush     (flush0),
    .in_valid  (iv0),
    .in_ready  (ir0),
    .in_ctrl   (ic0),
    .in_data   (id0),
    .out_valid (ov0),
    .out_ready (or0),
    .out_ctrl  (oc0),
    .out_data  (od0),
    .count     (cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r);
    iv1 = v; ic1 = c; id1 = d; or1 = r;
  endtask

  task automatic drive0(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r);
    iv0 = v; ic0 = c; id0 = d; or0 = r;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst1 = 1'b1; flush1 = 1'b0; drive1(1'b0, '0, '0, 1'b0);
    rst0 = 1'b1; flush0 = 1'b0; drive0(1'b0, '0, '0, 1'b0);

    // Reset state of both instances
    tick();
    tick();
    check("rst1_out_valid", ov1, 0);
    check("rst1_out_ctrl",  oc1, 0);
    check("rst1_out_data",  od1, 0);
    check("rst1_count",     cnt1, 0);
    check("rst0_out_valid", ov0, 0);
    check("rst0_count",     cnt0, 0);
    rst1 = 1'b0;
    rst0 = 1'b0;
    #1;
    check("rst1_in_ready", ir1, 1);
    check("rst0_in_ready", ir0, 1);

    // Streaming with out_ready high: one entry per cycle, 1-cycle latency
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, 10'h3A5, 64'(i), 1'b1);
      drive0(1'b1, 10'h3A5, 64'(i), 1'b1);
      tick();
      check($sformatf("s1_data%0d", i), od1, 64'(i));
      check($sformatf("s1_valid%0d", i), ov1, 1);
      check($sformatf("s1_ctrl%0d", i), oc1, 10'h3A5);
      check($sformatf("s1_count%0d", i), cnt1, 1);
      check($sformatf("s1_ready%0d", i), ir1, 1);
      check($sformatf("s0_data%0d", i), od0, 64'(i));
      check($sformatf("s0_count%0d", i), cnt0, 1);
    end
    drive1(1'b0, '0, '0, 1'b1);
    drive0(1'b0, '0, '0, 1'b1);
    tick();
    check("s1_drain_valid", ov1, 0);
    check("s1_drain_ctrl",  oc1, 0);
    check("s1_drain_count", cnt1, 0);
    check("s0_drain_valid", ov0, 0);
    check("s0_drain_ctrl",  oc0, 0);

    // Skid: 3-cycle downstream stall during a continuous stream
    drive1(1'b1, 10'h011, 64'h10, 1'b1);
    tick();
    check("stall_e1_data",  od1, 64'h10);
    check("stall_e1_count", cnt1, 1);
    drive1(1'b1, 10'h011, 64'h11, 1'b0);
    tick();
    check("stall_e2_data",  od1, 64'h10);
    check("stall_e2_count", cnt1, 2);
    check("stall_e2_ready", ir1, 0);
    drive1(1'b1, 10'h011, 64'h12, 1'b0);
    tick();
    check("stall_e3_data",  od1, 64'h10);
    check("stall_e3_count", cnt1, 2);
    tick();
    check("stall_e4_ready", ir1, 0);
    check("stall_e4_count", cnt1, 2);
    drive1(1'b1, 10'h011, 64'h12, 1'b1);
    tick();
    check("stall_e5_data",  od1, 64'h11);
    check("stall_e5_count", cnt1, 1);
    check("stall_e5_ready", ir1, 1);
    tick();
    check("stall_e6_data",  od1, 64'h12);
    check("stall_e6_count", cnt1, 1);
    drive1(1'b0, '0, '0, 1'b1);
    tick();
    check("stall_e7_valid", ov1, 0);
    check("stall_e7_count", cnt1, 0);

    // Flush while full, with a valid input in the same cycle
    drive1(1'b1, 10'h2AA, 64'h20, 1'b0);
    tick();
    drive1(1'b1, 10'h2AA, 64'h21, 1'b0);
    tick();
    check("fl_full_count", cnt1, 2);
    flush1 = 1'b1;
    drive1(1'b1, 10'h2AA, 64'h22, 1'b1);
    tick();
    check("fl_valid", ov1, 0);
    check("fl_ctrl",  oc1, 0);
    check("fl_count", cnt1, 0);
    check("fl_ready", ir1, 1);
    flush1 = 1'b0;
    drive1(1'b0, '0, '0, 1'b1);
    tick();
    check("fl_after_valid", ov1, 0);
    drive1(1'b1, 10'h07F, 64'h30, 1'b1);
    tick();
    check("fl_next_data", od1, 64'h30);
    check("fl_next_ctrl", oc1, 10'h07F);
    drive1(1'b0, '0, '0, 1'b1);
    tick();
    check("fl_next_drain", ov1, 0);

    // Flush and reset together mid-stream
    drive1(1'b1, 10'h3FF, 64'h40, 1'b0);
    tick();
    check("fr_pre_valid", ov1, 1);
    rst1 = 1'b1;
    flush1 = 1'b1;
    drive1(1'b1, 10'h3FF, 64'h41, 1'b0);
    tick();
    check("fr_valid", ov1, 0);
    check("fr_ctrl",  oc1, 0);
    check("fr_data",  od1, 0);
    check("fr_count", cnt1, 0);
    check("fr_ready", ir1, 1);
    rst1 = 1'b0;
    flush1 = 1'b0;
    drive1(1'b1, 10'h155, 64'h50, 1'b1);
    tick();
    check("fr_first_valid", ov1, 1);
    check("fr_first_data",  od1, 64'h50);
    check("fr_first_ctrl",  oc1, 10'h155);
    drive1(1'b0, '0, '0, 1'b1);
    tick();
    check("fr_drain_valid", ov1, 0);

    // Single slot: held entry blocks input, then same-cycle replace
    drive0(1'b1, 10'h0F0, 64'h60, 1'b0);
    tick();
    check("r0_hold_data", od0, 64'h60);
    drive0(1'b0, '0, '0, 1'b0);
    #1;
    check("r0_ready_low", ir0, 0);
    drive0(1'b1, 10'h00F, 64'h61, 1'b1);
    #1;
    check("r0_ready_high", ir0, 1);
    tick();
    check("r0_repl_data",  od0, 64'h61);
    check("r0_repl_ctrl",  oc0, 10'h00F);
    check("r0_repl_count", cnt0, 1);
    drive0(1'b0, '0, '0, 1'b1);
    tick();
    check("r0_drain_valid", ov0, 0);
    check("r0_drain_ctrl",  oc0, 0);
    check("r0_drain_count", cnt0, 0);

    // Single slot: flush zeroes control but data register holds
    drive0(1'b1, 10'h1C3, 64'h70, 1'b0);
    tick();
    flush0 = 1'b1;
    drive0(1'b1, 10'h1C3, 64'h71, 1'b0);
    tick();
    check("f0_valid", ov0, 0);
    check("f0_ctrl",  oc0, 0);
    check("f0_count", cnt0, 0);
    check("f0_data_hold", od0, 64'h70);
    flush0 = 1'b0;
    drive0(1'b0, '0, '0, 1'b1);
    tick();
    check("f0_after_valid", ov0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
